// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port memory bus between the IF-stage fetch port and the
//   MEM-stage data port. Each access is a req/ack bus transaction. Read data is
//   returned in a register, and per-port stall flags tell the pipeline when an
//   access is still outstanding. When both ports request at once, data wins.
//   Immediately after a completion, the other port gets the bus, so neither
//   port can starve the other.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN):
//   When defined, an access is aborted once wait_cnt reaches TIMEOUT without
//   an ack. The aborted access returns 32'hDEAD_BEEF and sets the sticky
//   bus_err flag. When undefined, the arbiter waits for ack forever and
//   bus_err is tied low.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   inst_ren, inst_addr    fetch request and address (IF stage)
//   inst_data, inst_stall  registered fetched word; fetch still outstanding
//   mem_ren, mem_wen       data read / write request (MEM stage), mutually exclusive
//   mem_addr, mem_dout     data address and store data
//   mem_din, mem_stall     registered load data; data access still outstanding
//   bus_req, bus_we        transaction active; 1 = write
//   bus_addr, bus_wdata    address and store data, latched at issue
//   bus_rdata, bus_ack     read data; 1-cycle completion pulse
//   bus_err                sticky timeout flag
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_ren,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_stall,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    // wait_cnt is 5 bits wide, so TIMEOUT must lie in 1..31.
    if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT must be in 1..31");
    end

    typedef enum logic [2:0] {StIdle, StData, StInst, StDDone, StIDone} state_e;

    state_e            state_q, state_d;
    logic [4:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_we_q, bus_we_d;
    logic              bus_req_q, bus_req_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] inst_data_q, inst_data_d;
    logic              timeout_hit;
`ifdef MEM_ARB_TIMEOUT_EN
    logic              bus_err_q, bus_err_d;
`endif

    logic d_req, i_req, i_match;
    assign d_req   = mem_ren | mem_wen;
    assign i_req   = inst_ren;
    assign i_match = (inst_addr == lat_addr_q);

`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_hit = (wait_cnt_q == 5'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        lat_addr_d  = lat_addr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        bus_req_d   = bus_req_q;
        mem_din_d   = mem_din_q;
        inst_data_d = inst_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
        bus_err_d   = bus_err_q;
`endif
        unique case (state_q)
            // Arbitration states; bus_ack is deliberately ignored here.
            StIdle, StDDone, StIDone: begin
                if (d_req && (state_q != StDDone)) begin
                    state_d     = StData;
                    bus_addr_d  = mem_addr;
                    lat_addr_d  = mem_addr;
                    bus_we_d    = mem_wen;
                    bus_wdata_d = mem_dout;
                    bus_req_d   = 1'b1;
                    wait_cnt_d  = '0;
                end else if (i_req && !((state_q == StIDone) && i_match)) begin
                    // In StIDone, an address mismatch means the fetch was redirected:
                    // re-issue the fetch at the new address.
                    state_d     = StInst;
                    bus_addr_d  = inst_addr;
                    lat_addr_d  = inst_addr;
                    bus_we_d    = 1'b0;
                    bus_wdata_d = '0;
                    bus_req_d   = 1'b1;
                    wait_cnt_d  = '0;
                end else begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                end
            end
            StData, StInst: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (state_q == StData) begin
                        state_d = StDDone;
                        if (!bus_we_q) mem_din_d = bus_rdata;
                    end else begin
                        state_d     = StIDone;
                        inst_data_d = bus_rdata;
                    end
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    bus_err_d = 1'b1;
`endif
                    if (state_q == StData) begin
                        state_d = StDDone;
                        if (!bus_we_q) mem_din_d = DATA_W'(32'hDEAD_BEEF);
                    end else begin
                        state_d     = StIDone;
                        inst_data_d = DATA_W'(32'hDEAD_BEEF);
                    end
                end else if (wait_cnt_q != 5'd31) begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end
            end
            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            lat_addr_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            mem_din_q   <= '0;
            inst_data_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lat_addr_q  <= lat_addr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_req_q   <= bus_req_d;
            mem_din_q   <= mem_din_d;
            inst_data_q <= inst_data_d;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    // Stalls are gated by rst_n so that every output reads 0 while reset is held,
    // even if the pipeline keeps its requests asserted.
    assign mem_stall  = rst_n & d_req & (state_q != StDDone);
    assign inst_stall = rst_n & i_req & ~((state_q == StIDone) & i_match);

    assign inst_data = inst_data_q;
    assign mem_din   = mem_din_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule
